alu_cmd_sequencer: RTL

Initiator side of the 16-bit ALU operand/opcode interface. Accepts ALU commands (A, B, opcode) over a valid/ready stream, buffers them in a small FIFO, drives each command onto the combinational ALU's A/B/opcode inputs, and holds it for a fixed settle window. It then captures the ALU's 17-bit Y and carry-out and returns them on a valid/ready result stream. It sits between the accelerator's control datapath and the ALU instance, so multi-cycle callers never have to hold ALU operands stable themselves.

---
 rtl/alu_cmd_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator side of the 16-bit ALU operand/opcode interface. Commands
// {A, B, opcode} arrive on a valid/ready stream and are queued in a small FIFO.
// Each command in turn is driven onto the ALU inputs from registers. It is held
// there for SETTLE cycles. The ALU result (17-bit Y plus carry-out) is then
// captured and offered on a valid/ready result stream.
//
// Parameters
//   DEPTH   command FIFO entries (power of two, >= 2)
//   SETTLE  cycles operands are held on the ALU before capture (>= 1)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command stream handshake
//   cmd_a, cmd_b, cmd_op       command payload (operands, opcode)
//   alu_a, alu_b, alu_op       registered operands/opcode to the ALU
//   alu_y, alu_co              combinational ALU result and carry-out
//   res_valid/res_ready        result stream handshake
//   res_y, res_co, res_op      captured result, carry and producing opcode
//   cmd_level                  FIFO occupancy
//   busy                       FSM active or commands queued
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_a,
  input  logic [15:0]              cmd_b,
  input  logic [2:0]               cmd_op,
  output logic [15:0]              alu_a,
  output logic [15:0]              alu_b,
  output logic [2:0]               alu_op,
  input  logic [16:0]              alu_y,
  input  logic                     alu_co,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [16:0]              res_y,
  output logic                     res_co,
  output logic [2:0]               res_op,
  output logic [$clog2(DEPTH):0]   cmd_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // The settle counter runs 0..SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW = 16 + 16 + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] entry_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // Ready depends on the registered count only: a pop in the same cycle does
  // not open a slot until the following cycle.
  assign cmd_ready = (count_reg != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = entry_reg[rd_ptr_reg];

  // Storage carries no reset; pointers and count define what is valid, so
  // clearing them is enough to discard queued commands.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_reg[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t        state_reg,     state_next;
  logic [SW-1:0] settle_reg,    settle_next;
  logic [15:0]   alu_a_reg,     alu_a_next;
  logic [15:0]   alu_b_reg,     alu_b_next;
  logic [2:0]    alu_op_reg,    alu_op_next;
  logic          res_valid_reg, res_valid_next;
  logic [16:0]   res_y_reg,     res_y_next;
  logic          res_co_reg,    res_co_next;
  logic [2:0]    res_op_reg,    res_op_next;

  always_comb begin
    state_next     = state_reg;
    settle_next    = settle_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_op_next    = alu_op_reg;
    res_valid_next = res_valid_reg;
    res_y_next     = res_y_reg;
    res_co_next    = res_co_reg;
    res_op_next    = res_op_reg;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop         = 1'b1;
          alu_a_next  = head[EW-1 -: 16];
          alu_b_next  = head[18:3];
          alu_op_next = head[2:0];
          settle_next = '0;
          state_next  = DRIVE;
        end
      end

      DRIVE: begin
        if (settle_reg == SW'(SETTLE - 1)) begin
          // Operands have been stable for SETTLE cycles: sample the ALU.
          res_y_next     = alu_y;
          res_co_next    = alu_co;
          res_op_next    = alu_op_reg;
          res_valid_next = 1'b1;
          state_next     = HOLD;
        end else begin
          settle_next = settle_reg + SW'(1);
        end
      end

      HOLD: begin
        if (res_ready) begin
          // Result consumed. Chain straight into the next command when one is
          // queued, so streaming costs only one HOLD cycle per result.
          res_valid_next = 1'b0;
          if (count_reg != '0) begin
            pop         = 1'b1;
            alu_a_next  = head[EW-1 -: 16];
            alu_b_next  = head[18:3];
            alu_op_next = head[2:0];
            settle_next = '0;
            state_next  = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    // Push and pop together leave the occupancy unchanged.
    count_next = count_reg + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      settle_reg    <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      res_valid_reg <= 1'b0;
      res_y_reg     <= '0;
      res_co_reg    <= 1'b0;
      res_op_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      settle_reg    <= settle_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_op_reg    <= alu_op_next;
      res_valid_reg <= res_valid_next;
      res_y_reg     <= res_y_next;
      res_co_reg    <= res_co_next;
      res_op_reg    <= res_op_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign res_valid = res_valid_reg;
  assign res_y     = res_y_reg;
  assign res_co    = res_co_reg;
  assign res_op    = res_op_reg;
  assign cmd_level = count_reg;
  assign busy      = (state_reg != IDLE) || (count_reg != '0);

endmodule
